uart_tx_arbiter: RTL and testbench

Shares a single UART transmit line among NUM_REQ byte producers. A round-robin arbiter grants one requester at a time through a valid/ready handshake, latches its byte, and sequences a bit-serial engine that emits an 8N1 frame: start bit, 8 data bits LSB first, stop bit. The block sits between on-chip byte sources (status reporters, debug taps) and the board-level tx pin, and replaces free-running transmit logic with on-demand, contention-free framing.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_frame.sv | 118 +++++++++++
 rtl/uart_tx_arbiter.sv | 83 ++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // PARITY exists in the encoding in every build; it is only reachable when
  // UART_TX_ARB_PARITY_EN is defined.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

endpackage

// File: rtl/uart_tx_frame.sv
// Bit-serial UART frame engine: baud counter, shift register and frame FSM.
// Emits 8N1 by default; 8E1 when UART_TX_ARB_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [BIT_W-1:0]     r_bit, w_bit_next;
  logic                 w_bit_end;
`ifdef UART_TX_ARB_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign o_busy    = (r_state != IDLE);

  // Frame state, baud counter, shift register and bit index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
`ifdef UART_TX_ARB_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
`ifdef UART_TX_ARB_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // Next-state logic; the counter restarts at every bit boundary.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = w_bit_end ? '0 : r_cnt + 1'b1;
    w_shift_next  = r_shift;
    w_bit_next    = r_bit;
    o_done        = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
    w_parity_next = r_parity;
`endif
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (i_start) begin
          w_state_next  = START;
          w_shift_next  = i_byte;
          w_bit_next    = '0;
`ifdef UART_TX_ARB_PARITY_EN
          w_parity_next = ^i_byte;
`endif
        end
      end
      START: if (w_bit_end) w_state_next = DATA;
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
`ifdef UART_TX_ARB_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      PARITY: if (w_bit_end) w_state_next = STOP;
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          o_done       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Serial line level, decoded from the current state.
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      START:  o_tx = 1'b0;
      DATA:   o_tx = r_shift[0];
`ifdef UART_TX_ARB_PARITY_EN
      PARITY: o_tx = r_parity;
`endif
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx line among NUM_REQ byte producers.
// Optional even parity: define UART_TX_ARB_PARITY_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                                           clk_50M,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_valid,
  input  logic [DATA_BITS*NUM_REQ-1:0]                   req_data,
  output logic [NUM_REQ-1:0]                             req_ready,
  output logic                                           tx,
  output logic                                           busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   r_ready, w_onehot;
  logic [ID_W-1:0]      r_grant_id, r_ptr, w_sel;
  logic                 w_found, w_can_grant, w_busy, w_done;
  logic [DATA_BITS-1:0] w_byte;

  // Grant while idle, or on the last STOP cycle so only one IDLE cycle separates frames.
  assign w_can_grant = (!w_busy && (r_ready == '0)) || w_done;

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    w_found  = 1'b0;
    w_sel    = '0;
    w_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_sel   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_onehot[w_sel] = w_found;
  end

  // Byte of the requester being handshaken this cycle.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_ready[i]) w_byte = req_data[DATA_BITS*i +: DATA_BITS];
    end
  end

  // Registered ready pulse, grant index and round-robin pointer.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_ready    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else begin
      r_ready <= '0;
      if (w_can_grant && w_found) begin
        r_ready    <= w_onehot;
        r_grant_id <= w_sel;
        r_ptr      <= ID_W'((int'(w_sel) + 1) % NUM_REQ);
      end
    end
  end

  uart_tx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame (
    .i_clk  (clk_50M),
    .i_rst  (rst),
    .i_start(|r_ready),
    .i_byte (w_byte),
    .o_tx   (tx),
    .o_busy (w_busy),
    .o_done (w_done)
  );

  assign req_ready = r_ready;
  assign busy      = w_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, CLKS_PER_BIT=4).
module tb_uart_tx_arbiter;

  localparam int CPB  = 4;
  localparam int NREQ = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FLEN = 11 * CPB;
`else
  localparam int FLEN = 10 * CPB;
`endif

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx, busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] cap_wave;
  int          cap_busy_cnt, cap_ready_cnt;
  logic        cap_gap_busy;
  logic [3:0]  cap_gap_ready;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk_50M = ~clk_50M;

  // Expected tx waveform, one bit per clock cycle of the frame.
  function automatic logic [43:0] exp_wave(input logic [7:0] b);
    logic [43:0] w;
    int slot;
    w = '0;
    for (int c = 0; c < FLEN; c++) begin
      slot = c / CPB;
      if (slot == 0) w[c] = 1'b0;
      else if (slot <= 8) w[c] = b[slot-1];
      else if (slot == 9 && FLEN == 44) w[c] = ^b;
      else w[c] = 1'b1;
    end
    return w;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Waits (bounded) for a req_ready pulse, sampled on falling edges.
  task automatic wait_ready(output int id, output int lat);
    id  = -1;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_50M);
      if (req_ready !== 4'b0000) begin
        id  = onehot_idx(req_ready);
        lat = c;
        return;
      end
    end
  endtask

  // Records FLEN frame cycles after the ready cycle, then the following gap cycle.
  task automatic capture_frame();
    cap_wave      = '0;
    cap_busy_cnt  = 0;
    cap_ready_cnt = 0;
    for (int c = 0; c < FLEN; c++) begin
      @(negedge clk_50M);
      cap_wave[c] = tx;
      if (busy === 1'b1) cap_busy_cnt++;
      if (req_ready !== 4'b0000) cap_ready_cnt++;
    end
    @(negedge clk_50M);
    cap_gap_busy  = busy;
    cap_gap_ready = req_ready;
  endtask

  task automatic test_reset();
    @(negedge clk_50M);
    n_checks += 4;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    @(negedge clk_50M);
    rst = 1'b0;
    repeat (2) @(negedge clk_50M);
    n_checks++;
    if (req_ready !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet got ready=%b busy=%b want 0000/0", req_ready, busy);
    end
  endtask

  task automatic test_round_robin();
    int id, lat;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    @(posedge clk_50M); #1;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'h10 + 8'(i * 17);
    req_valid = 4'b1111;
    wait_ready(id, lat);
    for (int n = 0; n < 5; n++) begin
      n_checks += 6;
      if (id !== exp_ids[n]) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", n, id, exp_ids[n]); end
      if (grant_id !== 2'(exp_ids[n])) begin
        n_fail++; $display("FAIL rr_gid[%0d] got %0d want %0d", n, grant_id, exp_ids[n]);
      end
      if (n == 4) begin @(posedge clk_50M); #1; req_valid = 4'b0000; end
      capture_frame();
      if (cap_wave !== exp_wave(8'h10 + 8'(exp_ids[n] * 17))) begin
        n_fail++; $display("FAIL rr_wave[%0d] got %h want %h", n, cap_wave,
                           exp_wave(8'h10 + 8'(exp_ids[n] * 17)));
      end
      if (cap_busy_cnt !== FLEN) begin
        n_fail++; $display("FAIL rr_busy[%0d] got %0d want %0d", n, cap_busy_cnt, FLEN);
      end
      if (cap_ready_cnt !== 0) begin
        n_fail++; $display("FAIL rr_ready_busy[%0d] got %0d want 0", n, cap_ready_cnt);
      end
      if (cap_gap_busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d] got %b want 0", n, cap_gap_busy); end
      n_checks++;
      if (n < 4) begin
        if (cap_gap_ready !== 4'(1 << exp_ids[n+1])) begin
          n_fail++; $display("FAIL rr_next[%0d] got %b want %b", n, cap_gap_ready, 4'(1 << exp_ids[n+1]));
        end
        id = onehot_idx(cap_gap_ready);
      end else if (cap_gap_ready !== 4'b0000) begin
        n_fail++; $display("FAIL rr_end got %b want 0000", cap_gap_ready);
      end
    end
  endtask

  task automatic test_single_byte();
    int id, lat;
    @(posedge clk_50M); #1;
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    wait_ready(id, lat);
    n_checks += 3;
    if (id !== 2) begin n_fail++; $display("FAIL single_id got %0d want 2", id); end
    // Registered grant: first falling edge after valid sees nothing, the next sees ready.
    if (lat !== 2) begin n_fail++; $display("FAIL single_latency got %0d want 2", lat); end
    if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid got %0d want 2", grant_id); end
    @(posedge clk_50M); #1;
    req_valid = 4'b0000;
    capture_frame();
    n_checks += 5;
    if (cap_wave !== exp_wave(8'hA5)) begin
      n_fail++; $display("FAIL single_wave got %h want %h", cap_wave, exp_wave(8'hA5));
    end
    if (cap_busy_cnt !== FLEN) begin n_fail++; $display("FAIL single_busy got %0d want %0d", cap_busy_cnt, FLEN); end
    if (cap_ready_cnt !== 0) begin n_fail++; $display("FAIL single_ready_busy got %0d want 0", cap_ready_cnt); end
    if (cap_gap_busy !== 1'b0) begin n_fail++; $display("FAIL single_gap got %b want 0", cap_gap_busy); end
    if (cap_gap_ready !== 4'b0) begin n_fail++; $display("FAIL single_once got %b want 0000", cap_gap_ready); end
  endtask

  task automatic test_withdrawal();
    int id, lat;
    @(posedge clk_50M); #1;
    req_data[7:0] = 8'h3C;
    req_data[15:8] = 8'hEE;
    req_data[31:24] = 8'h5A;
    req_valid = 4'b0001;
    wait_ready(id, lat);
    n_checks++;
    if (id !== 0) begin n_fail++; $display("FAIL wd_first got %0d want 0", id); end
    @(posedge clk_50M); #1;
    req_valid = 4'b1000;
    fork
      capture_frame();
      begin
        repeat (10) @(posedge clk_50M);
        #1 req_valid[1] = 1'b1;
        @(posedge clk_50M);
        #1 req_valid[1] = 1'b0;
      end
    join
    n_checks += 4;
    if (cap_wave !== exp_wave(8'h3C)) begin
      n_fail++; $display("FAIL wd_wave0 got %h want %h", cap_wave, exp_wave(8'h3C));
    end
    if (cap_ready_cnt !== 0) begin n_fail++; $display("FAIL wd_ready_busy got %0d want 0", cap_ready_cnt); end
    if (cap_gap_ready !== 4'b1000) begin n_fail++; $display("FAIL wd_next got %b want 1000", cap_gap_ready); end
    if (grant_id !== 2'd3) begin n_fail++; $display("FAIL wd_gid got %0d want 3", grant_id); end
    @(posedge clk_50M); #1;
    req_valid = 4'b0000;
    capture_frame();
    n_checks += 2;
    if (cap_wave !== exp_wave(8'h5A)) begin
      n_fail++; $display("FAIL wd_wave3 got %h want %h", cap_wave, exp_wave(8'h5A));
    end
    if (cap_gap_ready !== 4'b0) begin n_fail++; $display("FAIL wd_end got %b want 0000", cap_gap_ready); end
  endtask

  task automatic test_reset_mid_frame();
    int id, lat;
    @(posedge clk_50M); #1;
    req_data[7:0] = 8'h00;
    req_valid = 4'b0001;
    wait_ready(id, lat);
    @(posedge clk_50M); #1;
    req_valid = 4'b0000;
    repeat (10) @(negedge clk_50M);
    n_checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre got busy=%b tx=%b want 1/0", busy, tx);
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx got %b want 1", tx); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (req_ready !== 4'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_rst_gid got %0d want 0", grant_id); end
    @(negedge clk_50M);
    rst = 1'b0;
    @(posedge clk_50M); #1;
    req_data[23:16] = 8'h96;
    req_valid = 4'b0100;
    wait_ready(id, lat);
    n_checks++;
    if (id !== 2) begin n_fail++; $display("FAIL mid_fresh_id got %0d want 2", id); end
    @(posedge clk_50M); #1;
    req_valid = 4'b0000;
    capture_frame();
    n_checks += 2;
    if (cap_wave !== exp_wave(8'h96)) begin
      n_fail++; $display("FAIL mid_fresh_wave got %h want %h", cap_wave, exp_wave(8'h96));
    end
    if (cap_busy_cnt !== FLEN) begin n_fail++; $display("FAIL mid_fresh_busy got %0d want %0d", cap_busy_cnt, FLEN); end
  endtask

`ifdef UART_TX_ARB_PARITY_EN
  task automatic test_parity();
    int id, lat;
    logic [7:0] bytes[2] = '{8'h07, 8'h03};
    logic       pars[2]  = '{1'b1, 1'b0};
    for (int n = 0; n < 2; n++) begin
      @(posedge clk_50M); #1;
      req_data[15:8] = bytes[n];
      req_valid = 4'b0010;
      wait_ready(id, lat);
      @(posedge clk_50M); #1;
      req_valid = 4'b0000;
      capture_frame();
      n_checks += 3;
      if (cap_wave[36] !== pars[n]) begin
        n_fail++; $display("FAIL par_bit[%0d] got %b want %b", n, cap_wave[36], pars[n]);
      end
      if (cap_busy_cnt !== 44) begin n_fail++; $display("FAIL par_len[%0d] got %0d want 44", n, cap_busy_cnt); end
      if (cap_wave !== exp_wave(bytes[n])) begin
        n_fail++; $display("FAIL par_wave[%0d] got %h want %h", n, cap_wave, exp_wave(bytes[n]));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_byte();
    test_withdrawal();
    test_reset_mid_frame();
`ifdef UART_TX_ARB_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
